dr32e_branch_resolve: RTL and testbench
=======================================

DR32E_BRANCH_RESOLVE -- requirements
Module: dr32e_branch_resolve

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prediction-queue entries (power of 2, >=2).
REQ-002 SHALL have parameter CNT_W, default 16, width of statistics counters.
REQ-003 SHALL have port clk_i input 1 -- single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i input 1 -- reset, synchronous, active-high.
REQ-005 SHALL have port pred_valid_i input 1 -- fetch presents a predicted control-flow instruction.
REQ-006 SHALL have port pred_ready_o output 1 -- queue can accept an entry.
REQ-007 SHALL have port pred_pc_i input 32 -- PC of the predicted instruction.
REQ-008 SHALL have port pred_taken_i input 1 -- predicted direction.
REQ-009 SHALL have port pred_target_i input 32 -- predicted target (don't-care when not taken).
REQ-010 SHALL have port res_valid_i input 1 -- execute presents the in-order resolved outcome.
REQ-011 SHALL have port res_ready_o output 1 -- an entry is available to resolve.
REQ-012 SHALL have port res_taken_i input 1 -- actual direction.
REQ-013 SHALL have port res_target_i input 32 -- actual target.
REQ-014 SHALL have port flush_i input 1 -- exception/trap flush, discards all outstanding entries.
REQ-015 SHALL have port redirect_o output 1 -- one-cycle fetch redirect pulse on mispredict.
REQ-016 SHALL have port redirect_pc_o output 32 -- correct next PC.
REQ-017 SHALL have ports upd_valid_o 1, upd_pc_o 32, upd_taken_o 1, upd_target_o 32, all outputs -- predictor training write.
REQ-018 SHALL have ports br_count_o CNT_W and mispred_count_o CNT_W, outputs -- statistics.

Function
REQ-019 SHALL hold predictions in an in-order FIFO of DEPTH entries (pc, taken, target) with wrap-around read/write pointers and an occupancy count 0..DEPTH.
REQ-020 SHALL drive pred_ready_o = (count != DEPTH) and res_ready_o = (count != 0), combinationally from registered state only.
REQ-021 SHALL enqueue when pred_valid_i && pred_ready_o; when full, an enqueue is refused even if a dequeue occurs that cycle.
REQ-022 SHALL dequeue the oldest entry when res_valid_i && res_ready_o; res_valid_i while empty is ignored with no output effect.
REQ-023 SHALL support enqueue and dequeue in the same cycle, count unchanged.
REQ-024 SHALL declare mispredict when res_taken_i != entry.taken, or when both taken and res_target_i != entry.target.
REQ-025 SHALL, on mispredict, assert redirect_o for exactly the next cycle with redirect_pc_o = res_target_i if res_taken_i else entry.pc + 4 (mod 2^32).
REQ-026 SHALL, on mispredict, empty the queue (younger entries are wrong-path), including dropping any enqueue in the same cycle.
REQ-027 SHALL, on every dequeue, assert upd_valid_o the next cycle for one cycle with upd_pc_o = entry.pc, upd_taken_o = res_taken_i, upd_target_o = res_target_i.
REQ-028 SHALL increment br_count_o per dequeue and mispred_count_o per mispredict, both saturating at 2^CNT_W-1.
REQ-029 SHALL, on flush_i, empty the queue and suppress any dequeue/enqueue that cycle (no redirect, no update, no count change); flush_i has priority over all other events.
REQ-030 SHALL hold redirect_pc_o and upd_* data stable between pulses (registered, updated only on their valid).
REQ-031 SHALL have a total latency of 1 cycle from resolve handshake to redirect_o/upd_valid_o.

Reset
REQ-032 SHALL, while rst_i is high at a clock edge, clear pointers and count, drive redirect_o=0, upd_valid_o=0, redirect_pc_o=0, upd_pc_o=0, upd_taken_o=0, upd_target_o=0, br_count_o=0, mispred_count_o=0.
REQ-033 SHALL, on reset mid-operation, discard all entries and any pending pulse; pred_ready_o=1, res_ready_o=0 the cycle after reset deasserts.

Verification
REQ-034 Enqueue pc=0x100 taken=1 tgt=0x200; resolve taken=1 tgt=0x200 -> next cycle upd_valid_o=1 upd_pc_o=0x100, redirect_o=0, br_count_o=1, mispred_count_o=0.
REQ-035 Enqueue pc=0x100 taken=0, pc=0x104 taken=0; resolve first with taken=1 tgt=0x300 -> redirect_o=1 redirect_pc_o=0x300, res_ready_o=0 after, mispred_count_o=1.
REQ-036 Enqueue pc=0xFFFFFFFC taken=1; resolve taken=0 -> redirect_pc_o=0x00000000 (wrap).
REQ-037 Fill DEPTH=4 entries -> pred_ready_o=0; assert pred_valid_i with dequeue same cycle -> new entry refused, count=3; then 8 mixed enqueue/dequeue cycles -> FIFO order preserved across pointer wrap.
REQ-038 Queue with 3 entries, flush_i=1 with simultaneous res_valid_i mismatch -> no redirect, no upd_valid_o, counts unchanged, res_ready_o=0.
REQ-039 Force mispred_count_o to 0xFFFF via 65535+ mispredicts (or CNT_W=4 build, 20 mispredicts) -> counter holds at max; rst_i mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/dr32e_branch_resolve.sv
// -----------------------------------------------------------------------------
// dr32e_branch_resolve
//
// Purpose:
//   Branch resolution unit. It holds control-flow predictions made by fetch in
//   an in-order FIFO. Each prediction is compared with the in-order outcome
//   that execute presents. The unit produces:
//     - a one-cycle fetch redirect when a prediction was wrong,
//     - a one-cycle predictor training write for every resolved entry,
//     - saturating statistics counters.
//
// Parameters:
//   DEPTH  - prediction queue entries (power of 2, >= 2)
//   CNT_W  - width of the statistics counters
//
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   pred_valid_i / pred_ready_o     enqueue handshake from fetch
//   pred_pc_i, pred_taken_i,
//   pred_target_i                   predicted instruction data
//   res_valid_i / res_ready_o       resolve handshake from execute
//   res_taken_i, res_target_i       actual outcome
//   flush_i                         discard all entries; suppresses all events
//   redirect_o, redirect_pc_o       mispredict redirect pulse and correct PC
//   upd_valid_o, upd_pc_o,
//   upd_taken_o, upd_target_o       predictor training write
//   br_count_o, mispred_count_o     resolved-branch and mispredict counters
// -----------------------------------------------------------------------------
module dr32e_branch_resolve #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pred_valid_i,
  output logic             pred_ready_o,
  input  logic [31:0]      pred_pc_i,
  input  logic             pred_taken_i,
  input  logic [31:0]      pred_target_i,
  input  logic             res_valid_i,
  output logic             res_ready_o,
  input  logic             res_taken_i,
  input  logic [31:0]      res_target_i,
  input  logic             flush_i,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o,
  output logic             upd_valid_o,
  output logic [31:0]      upd_pc_o,
  output logic             upd_taken_o,
  output logic [31:0]      upd_target_o,
  output logic [CNT_W-1:0] br_count_o,
  output logic [CNT_W-1:0] mispred_count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_C = OCC_W'(DEPTH);

  // Saturating increment for the statistics counters
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // Queue storage (data only; validity is tracked by the pointers/count)
  logic [31:0]      pc_mem_q     [DEPTH];
  logic             taken_mem_q  [DEPTH];
  logic [31:0]      target_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;

  logic             redirect_q, redirect_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             upd_valid_q, upd_valid_d;
  logic [31:0]      upd_pc_q, upd_pc_d;
  logic             upd_taken_q, upd_taken_d;
  logic [31:0]      upd_target_q, upd_target_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  logic             enq_s;
  logic             deq_s;
  logic             mispred_s;
  logic [31:0]      head_pc_s;
  logic             head_taken_s;
  logic [31:0]      head_target_s;

  // Readiness depends on registered occupancy only. A full queue refuses an
  // enqueue even if a dequeue happens in the same cycle.
  assign pred_ready_o = (count_q != FULL_C);
  assign res_ready_o  = (count_q != OCC_W'(0));

  // Flush overrides every handshake that cycle.
  assign enq_s = pred_valid_i & pred_ready_o & ~flush_i;
  assign deq_s = res_valid_i  & res_ready_o  & ~flush_i;

  assign head_pc_s     = pc_mem_q[rd_ptr_q];
  assign head_taken_s  = taken_mem_q[rd_ptr_q];
  assign head_target_s = target_mem_q[rd_ptr_q];

  // The target is compared only when both the prediction and the outcome say taken.
  assign mispred_s = deq_s &
                     ((res_taken_i != head_taken_s) |
                      (res_taken_i & head_taken_s & (res_target_i != head_target_s)));

  // Next-state logic: queue pointers, output pulses and counters
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    upd_valid_d   = 1'b0;
    upd_pc_d      = upd_pc_q;
    upd_taken_d   = upd_taken_q;
    upd_target_d  = upd_target_q;
    br_cnt_d      = br_cnt_q;
    mis_cnt_d     = mis_cnt_q;

    if (flush_i || mispred_s) begin
      // Everything still queued is wrong-path, including a same-cycle enqueue.
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {OCC_W{1'b0}};
    end else begin
      if (enq_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (deq_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({enq_s, deq_s})
        2'b10:   count_d = count_q + OCC_W'(1);
        2'b01:   count_d = count_q - OCC_W'(1);
        default: count_d = count_q;
      endcase
    end

    if (mispred_s) begin
      redirect_d    = 1'b1;
      redirect_pc_d = res_taken_i ? res_target_i : (head_pc_s + 32'd4);
      mis_cnt_d     = sat_inc(mis_cnt_q);
    end else begin
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
      mis_cnt_d     = mis_cnt_q;
    end

    if (deq_s) begin
      upd_valid_d  = 1'b1;
      upd_pc_d     = head_pc_s;
      upd_taken_d  = res_taken_i;
      upd_target_d = res_target_i;
      br_cnt_d     = sat_inc(br_cnt_q);
    end else begin
      upd_valid_d  = 1'b0;
      upd_pc_d     = upd_pc_q;
      upd_taken_d  = upd_taken_q;
      upd_target_d = upd_target_q;
      br_cnt_d     = br_cnt_q;
    end
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q      <= {PTR_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
      count_q       <= {OCC_W{1'b0}};
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
      upd_valid_q   <= 1'b0;
      upd_pc_q      <= 32'd0;
      upd_taken_q   <= 1'b0;
      upd_target_q  <= 32'd0;
      br_cnt_q      <= {CNT_W{1'b0}};
      mis_cnt_q     <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      upd_valid_q   <= upd_valid_d;
      upd_pc_q      <= upd_pc_d;
      upd_taken_q   <= upd_taken_d;
      upd_target_q  <= upd_target_d;
      br_cnt_q      <= br_cnt_d;
      mis_cnt_q     <= mis_cnt_d;
    end
  end

  // Queue data write. A slot whose write is later squashed is never read,
  // because the pointers are cleared in that case.
  always_ff @(posedge clk_i) begin
    if (enq_s) begin
      pc_mem_q[wr_ptr_q]     <= pred_pc_i;
      taken_mem_q[wr_ptr_q]  <= pred_taken_i;
      target_mem_q[wr_ptr_q] <= pred_target_i;
    end
  end

  assign redirect_o      = redirect_q;
  assign redirect_pc_o   = redirect_pc_q;
  assign upd_valid_o     = upd_valid_q;
  assign upd_pc_o        = upd_pc_q;
  assign upd_taken_o     = upd_taken_q;
  assign upd_target_o    = upd_target_q;
  assign br_count_o      = br_cnt_q;
  assign mispred_count_o = mis_cnt_q;

endmodule

// File: tb/tb_dr32e_branch_resolve.sv
// -----------------------------------------------------------------------------
// tb_dr32e_branch_resolve
//
// Directed self-checking bench for dr32e_branch_resolve. It uses DEPTH=4 and
// CNT_W=4 so that counter saturation is reached with a short run. Inputs are
// driven between clock edges. Outputs are sampled 1 time unit after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_dr32e_branch_resolve;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             pred_valid_i;
  logic             pred_ready_o;
  logic [31:0]      pred_pc_i;
  logic             pred_taken_i;
  logic [31:0]      pred_target_i;
  logic             res_valid_i;
  logic             res_ready_o;
  logic             res_taken_i;
  logic [31:0]      res_target_i;
  logic             flush_i;
  logic             redirect_o;
  logic [31:0]      redirect_pc_o;
  logic             upd_valid_o;
  logic [31:0]      upd_pc_o;
  logic             upd_taken_o;
  logic [31:0]      upd_target_o;
  logic [CNT_W-1:0] br_count_o;
  logic [CNT_W-1:0] mispred_count_o;

  int checks   = 0;
  int failures = 0;

  dr32e_branch_resolve #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .pred_valid_i    (pred_valid_i),
    .pred_ready_o    (pred_ready_o),
    .pred_pc_i       (pred_pc_i),
    .pred_taken_i    (pred_taken_i),
    .pred_target_i   (pred_target_i),
    .res_valid_i     (res_valid_i),
    .res_ready_o     (res_ready_o),
    .res_taken_i     (res_taken_i),
    .res_target_i    (res_target_i),
    .flush_i         (flush_i),
    .redirect_o      (redirect_o),
    .redirect_pc_o   (redirect_pc_o),
    .upd_valid_o     (upd_valid_o),
    .upd_pc_o        (upd_pc_o),
    .upd_taken_o     (upd_taken_o),
    .upd_target_o    (upd_target_o),
    .br_count_o      (br_count_o),
    .mispred_count_o (mispred_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle_inputs();
    pred_valid_i  = 1'b0;
    pred_pc_i     = 32'd0;
    pred_taken_i  = 1'b0;
    pred_target_i = 32'd0;
    res_valid_i   = 1'b0;
    res_taken_i   = 1'b0;
    res_target_i  = 32'd0;
    flush_i       = 1'b0;
  endtask

  // Advance one clock; outputs are stable 1 unit after the edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic enq(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    pred_valid_i  = 1'b1;
    pred_pc_i     = pc;
    pred_taken_i  = tk;
    pred_target_i = tgt;
    step();
    pred_valid_i  = 1'b0;
  endtask

  task automatic resolve(input logic tk, input logic [31:0] tgt);
    res_valid_i  = 1'b1;
    res_taken_i  = tk;
    res_target_i = tgt;
    step();
    res_valid_i  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pred_ready_o !== 1'b1) begin failures++; $display("FAIL rst_pred_ready got=%b exp=1", pred_ready_o); end
    checks++; if (res_ready_o !== 1'b0) begin failures++; $display("FAIL rst_res_ready got=%b exp=0", res_ready_o); end
    checks++; if (redirect_o !== 1'b0 || upd_valid_o !== 1'b0) begin failures++; $display("FAIL rst_pulses got=%b%b exp=00", redirect_o, upd_valid_o); end
    checks++; if (redirect_pc_o !== 32'd0 || upd_pc_o !== 32'd0 || upd_target_o !== 32'd0 || upd_taken_o !== 1'b0) begin failures++; $display("FAIL rst_data got=%h %h %h %b exp=0", redirect_pc_o, upd_pc_o, upd_target_o, upd_taken_o); end
    checks++; if (br_count_o !== 4'd0 || mispred_count_o !== 4'd0) begin failures++; $display("FAIL rst_counts got=%0d %0d exp=0 0", br_count_o, mispred_count_o); end
    // A resolve while the queue is empty has no effect.
    resolve(1'b1, 32'h0000_0500);
    checks++; if (upd_valid_o !== 1'b0 || redirect_o !== 1'b0 || br_count_o !== 4'd0) begin failures++; $display("FAIL empty_resolve got=%b %b %0d exp=0 0 0", upd_valid_o, redirect_o, br_count_o); end
  endtask

  task automatic test_correct();
    do_reset();
    enq(32'h0000_0100, 1'b1, 32'h0000_0200);
    checks++; if (res_ready_o !== 1'b1) begin failures++; $display("FAIL ok_res_ready got=%b exp=1", res_ready_o); end
    resolve(1'b1, 32'h0000_0200);
    checks++; if (upd_valid_o !== 1'b1 || upd_pc_o !== 32'h0000_0100) begin failures++; $display("FAIL ok_upd got=%b %h exp=1 00000100", upd_valid_o, upd_pc_o); end
    checks++; if (upd_taken_o !== 1'b1 || upd_target_o !== 32'h0000_0200) begin failures++; $display("FAIL ok_upd_data got=%b %h exp=1 00000200", upd_taken_o, upd_target_o); end
    checks++; if (redirect_o !== 1'b0) begin failures++; $display("FAIL ok_redirect got=%b exp=0", redirect_o); end
    checks++; if (br_count_o !== 4'd1 || mispred_count_o !== 4'd0) begin failures++; $display("FAIL ok_counts got=%0d %0d exp=1 0", br_count_o, mispred_count_o); end
    step();
    checks++; if (upd_valid_o !== 1'b0 || upd_pc_o !== 32'h0000_0100) begin failures++; $display("FAIL ok_upd_hold got=%b %h exp=0 00000100", upd_valid_o, upd_pc_o); end
  endtask

  task automatic test_mispredict();
    do_reset();
    enq(32'h0000_0100, 1'b0, 32'h0);
    enq(32'h0000_0104, 1'b0, 32'h0);
    resolve(1'b1, 32'h0000_0300);
    checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h0000_0300) begin failures++; $display("FAIL mp_redirect got=%b %h exp=1 00000300", redirect_o, redirect_pc_o); end
    checks++; if (res_ready_o !== 1'b0) begin failures++; $display("FAIL mp_flushq got=%b exp=0", res_ready_o); end
    checks++; if (mispred_count_o !== 4'd1 || br_count_o !== 4'd1) begin failures++; $display("FAIL mp_counts got=%0d %0d exp=1 1", br_count_o, mispred_count_o); end
    checks++; if (upd_valid_o !== 1'b1 || upd_pc_o !== 32'h0000_0100 || upd_taken_o !== 1'b1) begin failures++; $display("FAIL mp_upd got=%b %h %b exp=1 00000100 1", upd_valid_o, upd_pc_o, upd_taken_o); end
    step();
    checks++; if (redirect_o !== 1'b0 || redirect_pc_o !== 32'h0000_0300) begin failures++; $display("FAIL mp_pulse_end got=%b %h exp=0 00000300", redirect_o, redirect_pc_o); end
    // Both taken, wrong target; a same-cycle enqueue must be dropped.
    enq(32'h0000_0010, 1'b1, 32'h0000_0040);
    pred_valid_i = 1'b1;
    pred_pc_i    = 32'h0000_0020;
    pred_taken_i = 1'b0;
    resolve(1'b1, 32'h0000_0080);
    checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h0000_0080) begin failures++; $display("FAIL mp_target got=%b %h exp=1 00000080", redirect_o, redirect_pc_o); end
    checks++; if (res_ready_o !== 1'b0) begin failures++; $display("FAIL mp_enq_drop got=%b exp=0", res_ready_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    enq(32'hFFFF_FFFC, 1'b1, 32'h0000_0008);
    resolve(1'b0, 32'h0000_0000);
    checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h0000_0000) begin failures++; $display("FAIL pc_wrap got=%b %h exp=1 00000000", redirect_o, redirect_pc_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] model[$];
    logic [7:0]  pat_enq;
    logic [7:0]  pat_deq;
    logic [31:0] exp_pc;
    logic        de;
    logic        dd;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      enq(32'h0000_1000 + 32'(4 * i), 1'b0, 32'h0);
    end
    checks++; if (pred_ready_o !== 1'b0 || res_ready_o !== 1'b1) begin failures++; $display("FAIL full_ready got=%b %b exp=0 1", pred_ready_o, res_ready_o); end
    // Enqueue offered while full, with a dequeue in the same cycle: refused.
    pred_valid_i = 1'b1;
    pred_pc_i    = 32'hDEAD_0000;
    resolve(1'b0, 32'h0);
    pred_valid_i = 1'b0;
    checks++; if (upd_valid_o !== 1'b1 || upd_pc_o !== 32'h0000_1000) begin failures++; $display("FAIL full_deq got=%b %h exp=1 00001000", upd_valid_o, upd_pc_o); end
    checks++; if (pred_ready_o !== 1'b1) begin failures++; $display("FAIL full_count3 got=%b exp=1", pred_ready_o); end
    model = '{32'h0000_1004, 32'h0000_1008, 32'h0000_100C};
    pat_enq = 8'b1011_0111;
    pat_deq = 8'b1101_1011;
    for (int k = 0; k < 8; k++) begin
      de = pat_enq[k] && (model.size() < DEPTH);
      dd = pat_deq[k] && (model.size() > 0);
      exp_pc = dd ? model[0] : 32'h0;
      pred_valid_i = de;
      pred_pc_i    = 32'h0000_2000 + 32'(4 * k);
      pred_taken_i = 1'b0;
      res_valid_i  = dd;
      res_taken_i  = 1'b0;
      step();
      pred_valid_i = 1'b0;
      res_valid_i  = 1'b0;
      if (dd) void'(model.pop_front());
      if (de) model.push_back(32'h0000_2000 + 32'(4 * k));
      checks++; if (upd_valid_o !== dd) begin failures++; $display("FAIL mix_valid[%0d] got=%b exp=%b", k, upd_valid_o, dd); end
      if (dd) begin
        checks++; if (upd_pc_o !== exp_pc) begin failures++; $display("FAIL mix_order[%0d] got=%h exp=%h", k, upd_pc_o, exp_pc); end
      end
    end
    for (int n = 0; n < 8 && model.size() > 0; n++) begin
      exp_pc = model.pop_front();
      resolve(1'b0, 32'h0);
      checks++; if (upd_valid_o !== 1'b1 || upd_pc_o !== exp_pc) begin failures++; $display("FAIL drain_order[%0d] got=%b %h exp=1 %h", n, upd_valid_o, upd_pc_o, exp_pc); end
    end
    checks++; if (res_ready_o !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", res_ready_o); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      enq(32'h0000_3000 + 32'(4 * i), 1'b0, 32'h0);
    end
    flush_i      = 1'b1;
    pred_valid_i = 1'b1;
    pred_pc_i    = 32'h0000_4000;
    resolve(1'b1, 32'h0000_0500);
    flush_i      = 1'b0;
    pred_valid_i = 1'b0;
    checks++; if (redirect_o !== 1'b0 || upd_valid_o !== 1'b0) begin failures++; $display("FAIL flush_pulses got=%b %b exp=0 0", redirect_o, upd_valid_o); end
    checks++; if (br_count_o !== 4'd0 || mispred_count_o !== 4'd0) begin failures++; $display("FAIL flush_counts got=%0d %0d exp=0 0", br_count_o, mispred_count_o); end
    checks++; if (res_ready_o !== 1'b0 || pred_ready_o !== 1'b1) begin failures++; $display("FAIL flush_empty got=%b %b exp=0 1", res_ready_o, pred_ready_o); end
  endtask

  task automatic test_saturate_and_reset();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      enq(32'h0000_5000 + 32'(4 * i), 1'b0, 32'h0);
      resolve(1'b1, 32'h0000_0040);
    end
    checks++; if (mispred_count_o !== 4'hF || br_count_o !== 4'hF) begin failures++; $display("FAIL sat_counts got=%0d %0d exp=15 15", br_count_o, mispred_count_o); end
    enq(32'h0000_6000, 1'b0, 32'h0);
    enq(32'h0000_6004, 1'b0, 32'h0);
    rst_i = 1'b1;
    resolve(1'b1, 32'h0000_0040);
    checks++; if (redirect_o !== 1'b0 || upd_valid_o !== 1'b0 || redirect_pc_o !== 32'd0 || upd_pc_o !== 32'd0 || upd_target_o !== 32'd0 || upd_taken_o !== 1'b0) begin failures++; $display("FAIL midrst_outs got=%b %b %h %h %h %b exp=all 0", redirect_o, upd_valid_o, redirect_pc_o, upd_pc_o, upd_target_o, upd_taken_o); end
    checks++; if (br_count_o !== 4'd0 || mispred_count_o !== 4'd0) begin failures++; $display("FAIL midrst_counts got=%0d %0d exp=0 0", br_count_o, mispred_count_o); end
    rst_i = 1'b0;
    step();
    checks++; if (pred_ready_o !== 1'b1 || res_ready_o !== 1'b0) begin failures++; $display("FAIL midrst_ready got=%b %b exp=1 0", pred_ready_o, res_ready_o); end
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    test_reset();
    test_correct();
    test_mispredict();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_saturate_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
